// File: rtl/multichunk_addsub.sv
// multichunk_addsub: sequential adder-subtractor that handles WIDTH-bit
// operands in CHUNK-bit slices, one slice per cycle, with a registered carry
// between slices. Valid/ready handshake on both sides; zero and signed
// overflow flags are produced together with the final slice.
module multichunk_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             carry_reg;
  logic [KW-1:0]    k_reg;
  logic             cout_reg, overflow_reg, zero_reg;

  logic [CHUNK-1:0] a_slice [N];
  logic [CHUNK-1:0] b_slice [N];
  logic [CHUNK:0]   sum_full;
  logic             accept;
  logic             last_slice;

  // Split the operand registers into slices and build the result with the
  // current slice k replaced by the fresh sum (used both for the register
  // update and for the flags on the final slice).
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_slice[gi] = b_reg[gi*CHUNK +: CHUNK];
      assign result_next[gi*CHUNK +: CHUNK] =
        (k_reg == KW'(gi)) ? sum_full[CHUNK-1:0] : result_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // One CHUNK+1-bit slice sum; the top bit is the carry into the next slice.
  assign sum_full = {1'b0, a_slice[k_reg]} + {1'b0, b_slice[k_reg]}
                  + {{CHUNK{1'b0}}, carry_reg};

  assign accept     = in_valid && (state_reg == IDLE);
  assign last_slice = (k_reg == KW'(N - 1));

  // State register; reset forces IDLE immediately, discarding any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode: IDLE -> CALC on acceptance, CALC -> DONE after the
  // last slice, DONE -> IDLE when the consumer takes the result.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (last_slice) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands (subtract as a + ~b + ~cin), then ripple one
  // slice per CALC cycle; flags are latched on the final slice only, so the
  // outputs stay frozen while DONE waits for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      k_reg        <= '0;
      result_reg   <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b ^ {WIDTH{mode}};
      carry_reg <= cin ^ mode;
      k_reg     <= '0;
    end else if (state_reg == CALC) begin
      result_reg <= result_next;
      carry_reg  <= sum_full[CHUNK];
      k_reg      <= last_slice ? '0 : k_reg + 1'b1;
      if (last_slice) begin
        cout_reg     <= sum_full[CHUNK];
        overflow_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (result_next[WIDTH-1] != a_reg[WIDTH-1]);
        zero_reg     <= (result_next == '0);
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign cout      = cout_reg;
  assign overflow  = overflow_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_multichunk_addsub.sv
// tb_multichunk_addsub: directed checks on three configurations
// (32/8, 16/16 and 64/16) sharing one clock and reset.
module tb_multichunk_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid  [3];
  logic        out_ready [3];
  logic        mode      [3];
  logic        cin       [3];
  logic [63:0] a         [3];
  logic [63:0] b         [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        cout      [3];
  logic        ovf       [3];
  logic        zero      [3];
  logic [63:0] result    [3];
  logic [31:0] r32;
  logic [15:0] r16;
  logic [63:0] r64;

  assign result[0] = {32'h0, r32};
  assign result[1] = {48'h0, r16};
  assign result[2] = r64;

  int tests = 0;
  int fails = 0;

  multichunk_addsub #(.WIDTH(32), .CHUNK(8)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0][31:0]), .b(b[0][31:0]), .mode(mode[0]), .cin(cin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(r32),
    .cout(cout[0]), .overflow(ovf[0]), .zero(zero[0]));

  multichunk_addsub #(.WIDTH(16), .CHUNK(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1][15:0]), .b(b[1][15:0]), .mode(mode[1]), .cin(cin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(r16),
    .cout(cout[1]), .overflow(ovf[1]), .zero(zero[1]));

  multichunk_addsub #(.WIDTH(64), .CHUNK(16)) u_d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .mode(mode[2]), .cin(cin[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .result(r64),
    .cout(cout[2]), .overflow(ovf[2]), .zero(zero[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand set to instance s and wait (bounded) for out_valid.
  // With noisy set, in_valid is pulsed with random operands during CALC/DONE.
  task automatic op(input int s, input logic [63:0] av, input logic [63:0] bv,
                    input logic m, input logic c, input bit noisy, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready[s] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a[s] = av; b[s] = bv; mode[s] = m; cin[s] = c; in_valid[s] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[s] = 1'b0;
    lat = 0;
    while (!out_valid[s] && lat < 40) begin
      if (noisy) begin
        check("in_ready_low_in_calc", {63'h0, in_ready[s]}, 64'h0);
        in_valid[s] = 1'b1;
        a[s] = {$urandom, $urandom};
        b[s] = {$urandom, $urandom};
      end
      @(posedge clk);
      #1;
      lat++;
    end
    $display("[TB] dut%0d a=%0h b=%0h mode=%0d cin=%0d -> result=%0h cout=%0d ovf=%0d zero=%0d lat=%0d",
             s, av, bv, m, c, result[s], cout[s], ovf[s], zero[s], lat);
  endtask

  task automatic expect_out(input int s, input string tag, input logic [63:0] r,
                            input logic co, input logic ov, input logic z);
    @(negedge clk);
    check({tag, "_valid"}, {63'h0, out_valid[s]}, 64'h1);
    check({tag, "_result"}, result[s], r);
    check({tag, "_cout"}, {63'h0, cout[s]}, {63'h0, co});
    check({tag, "_ovf"}, {63'h0, ovf[s]}, {63'h0, ov});
    check({tag, "_zero"}, {63'h0, zero[s]}, {63'h0, z});
  endtask

  // Hand the result to the consumer and confirm out_valid/in_ready swap.
  task automatic release_out(input int s, input string tag);
    @(negedge clk);
    in_valid[s]  = 1'b0;
    out_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[s] = 1'b0;
    check({tag, "_rel_valid"}, {63'h0, out_valid[s]}, 64'h0);
    check({tag, "_rel_ready"}, {63'h0, in_ready[s]}, 64'h1);
  endtask

  initial begin
    int lat;
    logic [63:0] av, bv, rexp;
    logic        m, c, coexp, ovexp;
    logic [64:0] full;
    logic signed [65:0] sv;

    for (int s = 0; s < 3; s++) begin
      in_valid[s] = 0; out_ready[s] = 0; mode[s] = 0; cin[s] = 0; a[s] = 0; b[s] = 0;
    end

    // Reset state, sampled while rst_n is still low.
    #12;
    for (int s = 0; s < 3; s++) begin
      check("rst_in_ready", {63'h0, in_ready[s]}, 64'h1);
      check("rst_out_valid", {63'h0, out_valid[s]}, 64'h0);
      check("rst_result", result[s], 64'h0);
      check("rst_cout", {63'h0, cout[s]}, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ripple between slices
    op(0, 64'h0000_00FF, 64'h0000_0001, 1'b0, 1'b0, 1'b0, lat);
    check("t1_latency", 64'(lat), 64'd4);
    expect_out(0, "t1", 64'h0000_0100, 1'b0, 1'b0, 1'b0);
    release_out(0, "t1");

    // 2: subtract with borrow, then with borrow-in
    op(0, 64'h5, 64'h7, 1'b1, 1'b0, 1'b0, lat);
    expect_out(0, "t2a", 64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    release_out(0, "t2a");
    op(0, 64'h5, 64'h7, 1'b1, 1'b1, 1'b0, lat);
    expect_out(0, "t2b", 64'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    release_out(0, "t2b");

    // 3: signed overflow, add and subtract
    op(0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, lat);
    expect_out(0, "t3a", 64'h8000_0000, 1'b0, 1'b1, 1'b0);
    release_out(0, "t3a");
    op(0, 64'h8000_0000, 64'h1, 1'b1, 1'b0, 1'b0, lat);
    expect_out(0, "t3b", 64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    release_out(0, "t3b");

    // 4: carry into zero with back-pressure and ignored in_valid noise
    op(0, 64'hFFFF_FFFF, 64'h0, 1'b0, 1'b1, 1'b1, lat);
    check("t4_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      expect_out(0, "t4_hold", 64'h0, 1'b1, 1'b0, 1'b1);
      check("t4_in_ready", {63'h0, in_ready[0]}, 64'h0);
      in_valid[0] = 1'b1;
      a[0] = {$urandom, $urandom};
      b[0] = {$urandom, $urandom};
    end
    release_out(0, "t4");

    // 5: reset in the second CALC cycle
    @(negedge clk);
    a[0] = 64'h1234_5678; b[0] = 64'h1111_1111; mode[0] = 0; cin[0] = 0; in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    check("t5_slice0", result[0], 64'h0000_0089);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {63'h0, out_valid[0]}, 64'h0);
    check("t5_rst_ready", {63'h0, in_ready[0]}, 64'h1);
    check("t5_rst_result", result[0], 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_valid", {63'h0, out_valid[0]}, 64'h0);
    end
    op(0, 64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0, 1'b0, lat);
    check("t5_latency", 64'(lat), 64'd4);
    expect_out(0, "t5", 64'h2345_6789, 1'b0, 1'b0, 1'b0);
    release_out(0, "t5");

    // 6a: single-slice configuration
    op(1, 64'h8000, 64'h8000, 1'b0, 1'b0, 1'b0, lat);
    check("t6a_latency", 64'(lat), 64'd1);
    expect_out(1, "t6a", 64'h0, 1'b1, 1'b1, 1'b1);
    release_out(1, "t6a");

    // 6b: 64/16 directed borrow case plus random ops vs 65-bit reference
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        av = 64'h0; bv = 64'h1; m = 1'b1; c = 1'b0;
      end else begin
        av = {$urandom, $urandom};
        bv = {$urandom, $urandom};
        m  = 1'($urandom_range(0, 1));
        c  = 1'($urandom_range(0, 1));
      end
      if (m) begin
        full  = {1'b0, av} - {1'b0, bv} - {64'h0, c};
        coexp = ~full[64];
        sv    = $signed({{2{av[63]}}, av}) - $signed({{2{bv[63]}}, bv}) - $signed({65'h0, c});
      end else begin
        full  = {1'b0, av} + {1'b0, bv} + {64'h0, c};
        coexp = full[64];
        sv    = $signed({{2{av[63]}}, av}) + $signed({{2{bv[63]}}, bv}) + $signed({65'h0, c});
      end
      rexp  = full[63:0];
      ovexp = (sv[64] != sv[63]);
      op(2, av, bv, m, c, 1'b0, lat);
      check("t6b_latency", 64'(lat), 64'd4);
      expect_out(2, "t6b", rexp, coexp, ovexp, (rexp == 64'h0));
      release_out(2, "t6b");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
